// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised edge/level lines plus software interrupts,
// fixed lowest-index priority, single outstanding request with acknowledge handshake.
module irq_ctrl #(
    parameter int IRQ_NUM_POW = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [(2**IRQ_NUM_POW)-1:0] irq_bi,
    input  logic                        sgi_req_i,
    input  logic [IRQ_NUM_POW-1:0]      sgi_code_bi,
    input  logic                        cfg_we_i,
    input  logic [1:0]                  cfg_addr_bi,
    input  logic [(2**IRQ_NUM_POW)-1:0] cfg_wdata_bi,
    output logic [(2**IRQ_NUM_POW)-1:0] cfg_rdata_bo,
    output logic                        irq_req_o,
    output logic [IRQ_NUM_POW-1:0]      irq_code_bo,
    input  logic                        irq_ack_i
);

    localparam int N = 2**IRQ_NUM_POW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] A_ENABLE  = 2'd0;
    localparam logic [1:0] A_MODE    = 2'd1;
    localparam logic [1:0] A_PENDING = 2'd2;
    localparam logic [1:0] A_SWSET   = 2'd3;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]           r_sync [SYNC_STAGES];
    logic [N-1:0]           r_hist;
    logic [N-1:0]           r_hw_pend;
    logic [N-1:0]           r_sw_pend;
    logic [N-1:0]           r_enable;
    logic [N-1:0]           r_mode;
    logic [1:0]             r_state;
    logic                   r_req;
    logic [IRQ_NUM_POW-1:0] r_code;

    logic [N-1:0]           w_sync;
    logic [N-1:0]           w_rise;
    logic                   w_ack;
    logic [N-1:0]           w_clr;
    logic [N-1:0]           w_set_sw;
    logic [N-1:0]           w_hw_next;
    logic [N-1:0]           w_sw_next;
    logic [N-1:0]           w_pend;
    logic [N-1:0]           w_elig;
    logic                   w_any;
    logic [IRQ_NUM_POW-1:0] w_win;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_hist;
    assign w_ack  = (r_state == ST_REQ) && irq_ack_i;

    // Clears come from the acknowledged line and from write-1-to-clear; sets are OR'd
    // in afterwards so a same-edge set always leaves the bit pending.
    assign w_clr = (w_ack ? (ONE << r_code) : '0)
                 | ((cfg_we_i && cfg_addr_bi == A_PENDING) ? cfg_wdata_bi : '0);
    assign w_set_sw = (sgi_req_i ? (ONE << sgi_code_bi) : '0)
                    | ((cfg_we_i && cfg_addr_bi == A_SWSET) ? cfg_wdata_bi : '0);

    assign w_hw_next = (r_mode & w_sync) | (~r_mode & ((r_hw_pend & ~w_clr) | w_rise));
    assign w_sw_next = (r_sw_pend & ~w_clr) | w_set_sw;

    assign w_pend = r_hw_pend | r_sw_pend;
    assign w_elig = w_pend & r_enable;
    assign w_any  = |w_elig;

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_elig[i]) w_win = i[IRQ_NUM_POW-1:0];
        end
    end

    always_comb begin
        cfg_rdata_bo = '0;
        case (cfg_addr_bi)
            A_ENABLE:  cfg_rdata_bo = r_enable;
            A_MODE:    cfg_rdata_bo = r_mode;
            A_PENDING: cfg_rdata_bo = w_pend;
            default:   cfg_rdata_bo = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: the synchroniser array is small flop storage, not RAM, so it is reset
            // like any other register to avoid phantom edges after reset.
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_hist    <= '0;
            r_hw_pend <= '0;
            r_sw_pend <= '0;
            r_enable  <= '0;
            r_mode    <= '0;
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_code    <= '0;
        end else begin
            r_sync[0] <= irq_bi;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_hist    <= w_sync;
            r_hw_pend <= w_hw_next;
            r_sw_pend <= w_sw_next;
            if (cfg_we_i && cfg_addr_bi == A_ENABLE) r_enable <= cfg_wdata_bi;
            if (cfg_we_i && cfg_addr_bi == A_MODE)   r_mode   <= cfg_wdata_bi;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_code  <= w_win;
                    end
                end
                ST_REQ: begin
                    if (irq_ack_i) begin
                        r_state <= ST_GAP;
                        r_req   <= 1'b0;
                        r_code  <= '0;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_code  <= '0;
                end
            endcase
        end
    end

    assign irq_req_o   = r_req;
    assign irq_code_bo = r_code;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_irq_ctrl;

    localparam int P = 4;
    localparam int S = 2;
    localparam int N = 2**P;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   irq_bi;
    logic           sgi_req_i;
    logic [P-1:0]   sgi_code_bi;
    logic           cfg_we_i;
    logic [1:0]     cfg_addr_bi;
    logic [N-1:0]   cfg_wdata_bi;
    logic [N-1:0]   cfg_rdata_bo;
    logic           irq_req_o;
    logic [P-1:0]   irq_code_bo;
    logic           irq_ack_i;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.IRQ_NUM_POW(P), .SYNC_STAGES(S)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .irq_bi       (irq_bi),
        .sgi_req_i    (sgi_req_i),
        .sgi_code_bi  (sgi_code_bi),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_bi  (cfg_addr_bi),
        .cfg_wdata_bi (cfg_wdata_bi),
        .cfg_rdata_bo (cfg_rdata_bo),
        .irq_req_o    (irq_req_o),
        .irq_code_bo  (irq_code_bo),
        .irq_ack_i    (irq_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [N-1:0] d);
        cfg_we_i = 1'b1; cfg_addr_bi = a; cfg_wdata_bi = d;
        tick();
        cfg_we_i = 1'b0; cfg_wdata_bi = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [N-1:0] d);
        cfg_addr_bi = a;
        #1;
        d = cfg_rdata_bo;
    endtask

    task automatic pulse_ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    // Bounded wait for a request; an expired budget is recorded as a failure.
    task automatic wait_req(input string name, input int budget);
        int n;
        n = 0;
        while (irq_req_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (irq_req_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: req=%b after %0d cycles, want 1", name, irq_req_o, n);
        end
    endtask

    task automatic test_reset();
        logic [N-1:0] d;
        // Reset must beat a simultaneous config write, SGI and ack.
        rst_ni = 1'b0;
        cfg_we_i = 1'b1; cfg_addr_bi = 2'd0; cfg_wdata_bi = '1;
        sgi_req_i = 1'b1; sgi_code_bi = 4'd3; irq_ack_i = 1'b1;
        tick(); tick();
        cfg_we_i = 1'b0; cfg_wdata_bi = '0; sgi_req_i = 1'b0; irq_ack_i = 1'b0;
        total++; if (irq_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", irq_req_o); end
        total++; if (irq_code_bo !== '0) begin bad++; $display("FAIL reset_code: got %0d want 0", irq_code_bo); end
        read_reg(2'd0, d);
        total++; if (d !== '0) begin bad++; $display("FAIL reset_enable: got %h want 0", d); end
        read_reg(2'd1, d);
        total++; if (d !== '0) begin bad++; $display("FAIL reset_mode: got %h want 0", d); end
        read_reg(2'd2, d);
        total++; if (d !== '0) begin bad++; $display("FAIL reset_pending: got %h want 0", d); end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        logic [N-1:0] d;
        cfg_write(2'd0, 16'h0005);
        irq_bi[2] = 1'b1;
        #1 irq_bi[0] = 1'b1;
        tick();
        irq_bi = '0;
        wait_req("prio_first", 10);
        total++; if (irq_code_bo !== 4'd0) begin bad++; $display("FAIL prio_code0: got %0d want 0", irq_code_bo); end
        read_reg(2'd2, d);
        total++; if (d !== 16'h0005) begin bad++; $display("FAIL prio_pend_both: got %h want 0005", d); end
        pulse_ack();
        total++; if (irq_req_o !== 1'b0) begin bad++; $display("FAIL prio_gap_req: got %b want 0", irq_req_o); end
        read_reg(2'd2, d);
        total++; if (d !== 16'h0004) begin bad++; $display("FAIL prio_pend_after_ack: got %h want 0004", d); end
        tick();
        total++; if (irq_req_o !== 1'b0) begin bad++; $display("FAIL prio_idle_req: got %b want 0", irq_req_o); end
        tick();
        total++; if (irq_req_o !== 1'b1 || irq_code_bo !== 4'd2) begin
            bad++; $display("FAIL prio_second: req=%b code=%0d want req=1 code=2", irq_req_o, irq_code_bo);
        end
        // Request must hold through an ENABLE change.
        cfg_write(2'd0, 16'h0000);
        total++; if (irq_req_o !== 1'b1 || irq_code_bo !== 4'd2) begin
            bad++; $display("FAIL prio_hold: req=%b code=%0d want req=1 code=2", irq_req_o, irq_code_bo);
        end
        pulse_ack();
        total++; if (irq_code_bo !== 4'd0) begin bad++; $display("FAIL prio_code_idle: got %0d want 0", irq_code_bo); end
        tick(); tick();
        read_reg(2'd2, d);
        total++; if (d !== '0) begin bad++; $display("FAIL prio_pend_clear: got %h want 0", d); end
    endtask

    task automatic test_enable_gate();
        logic [N-1:0] d;
        cfg_write(2'd3, 16'h0030);
        repeat (4) tick();
        total++; if (irq_req_o !== 1'b0) begin bad++; $display("FAIL gate_req: got %b want 0", irq_req_o); end
        pulse_ack();
        read_reg(2'd2, d);
        total++; if (d !== 16'h0030) begin bad++; $display("FAIL gate_stray_ack: got %h want 0030", d); end
        read_reg(2'd3, d);
        total++; if (d !== '0) begin bad++; $display("FAIL gate_swset_read: got %h want 0", d); end
        cfg_write(2'd0, 16'h0010);
        total++; if (irq_req_o !== 1'b0) begin bad++; $display("FAIL gate_early: got %b want 0", irq_req_o); end
        tick();
        total++; if (irq_req_o !== 1'b1 || irq_code_bo !== 4'd4) begin
            bad++; $display("FAIL gate_code4: req=%b code=%0d want req=1 code=4", irq_req_o, irq_code_bo);
        end
        pulse_ack();
        read_reg(2'd2, d);
        total++; if (d !== 16'h0020) begin bad++; $display("FAIL gate_pend_left: got %h want 0020", d); end
        cfg_write(2'd2, 16'h0020);
        read_reg(2'd2, d);
        total++; if (d !== '0) begin bad++; $display("FAIL gate_w1c: got %h want 0", d); end
        tick();
    endtask

    task automatic test_latency();
        int cyc;
        cfg_write(2'd0, 16'h0001);
        irq_bi[0] = 1'b1;
        cyc = 0;
        while (irq_req_o !== 1'b1 && cyc < 12) begin
            tick();
            cyc++;
            if (cyc == 1) irq_bi[0] = 1'b0;
        end
        // Edges: 1 capture + (S-1) sync stages + 1 pend + 1 request.
        total++; if (cyc !== S + 2) begin bad++; $display("FAIL latency_cycles: got %0d want %0d", cyc, S + 2); end
        total++; if (irq_code_bo !== 4'd0) begin bad++; $display("FAIL latency_code: got %0d want 0", irq_code_bo); end
        pulse_ack();
        tick(); tick();
    endtask

    task automatic test_level();
        logic [N-1:0] d;
        bit seen;
        cfg_write(2'd1, 16'h0008);
        cfg_write(2'd0, 16'h0008);
        irq_bi[3] = 1'b1;
        wait_req("level_first", 12);
        total++; if (irq_code_bo !== 4'd3) begin bad++; $display("FAIL level_code: got %0d want 3", irq_code_bo); end
        pulse_ack();
        total++; if (irq_req_o !== 1'b0) begin bad++; $display("FAIL level_gap: got %b want 0", irq_req_o); end
        tick(); tick();
        total++; if (irq_req_o !== 1'b1 || irq_code_bo !== 4'd3) begin
            bad++; $display("FAIL level_reassert: req=%b code=%0d want req=1 code=3", irq_req_o, irq_code_bo);
        end
        irq_bi[3] = 1'b0;
        repeat (S + 3) tick();
        total++; if (irq_req_o !== 1'b1 || irq_code_bo !== 4'd3) begin
            bad++; $display("FAIL level_hold: req=%b code=%0d want req=1 code=3", irq_req_o, irq_code_bo);
        end
        pulse_ack();
        seen = 1'b0;
        repeat (6) begin
            if (irq_req_o !== 1'b0) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL level_dropped: request seen=%b want 0", seen); end
        read_reg(2'd2, d);
        total++; if (d !== '0) begin bad++; $display("FAIL level_pend: got %h want 0", d); end
        cfg_write(2'd1, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] d;
        cfg_write(2'd0, 16'h0080);
        sgi_req_i = 1'b1; sgi_code_bi = 4'd7;
        tick();
        sgi_req_i = 1'b0;
        wait_req("b2b_first", 6);
        total++; if (irq_code_bo !== 4'd7) begin bad++; $display("FAIL b2b_code: got %0d want 7", irq_code_bo); end
        irq_ack_i = 1'b1; sgi_req_i = 1'b1; sgi_code_bi = 4'd7;
        tick();
        irq_ack_i = 1'b0; sgi_req_i = 1'b0;
        total++; if (irq_req_o !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b want 0", irq_req_o); end
        read_reg(2'd2, d);
        total++; if (d !== 16'h0080) begin bad++; $display("FAIL b2b_set_wins: got %h want 0080", d); end
        tick(); tick();
        total++; if (irq_req_o !== 1'b1 || irq_code_bo !== 4'd7) begin
            bad++; $display("FAIL b2b_again: req=%b code=%0d want req=1 code=7", irq_req_o, irq_code_bo);
        end
        pulse_ack();
        read_reg(2'd2, d);
        total++; if (d !== '0) begin bad++; $display("FAIL b2b_pend_clear: got %h want 0", d); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] d;
        cfg_write(2'd0, 16'hFFFF);
        cfg_write(2'd3, 16'h0100);
        wait_req("rstmid_req", 6);
        total++; if (irq_code_bo !== 4'd8) begin bad++; $display("FAIL rstmid_code8: got %0d want 8", irq_code_bo); end
        rst_ni = 1'b0;
        cfg_we_i = 1'b1; cfg_addr_bi = 2'd3; cfg_wdata_bi = 16'h0001;
        sgi_req_i = 1'b1; sgi_code_bi = 4'd2; irq_ack_i = 1'b1;
        tick();
        cfg_we_i = 1'b0; cfg_wdata_bi = '0; sgi_req_i = 1'b0; irq_ack_i = 1'b0;
        total++; if (irq_req_o !== 1'b0 || irq_code_bo !== '0) begin
            bad++; $display("FAIL rstmid_out: req=%b code=%0d want req=0 code=0", irq_req_o, irq_code_bo);
        end
        read_reg(2'd2, d);
        total++; if (d !== '0) begin bad++; $display("FAIL rstmid_pending: got %h want 0", d); end
        read_reg(2'd0, d);
        total++; if (d !== '0) begin bad++; $display("FAIL rstmid_enable: got %h want 0", d); end
        tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        total++; if (irq_req_o !== 1'b0) begin bad++; $display("FAIL rstmid_after: got %b want 0", irq_req_o); end
    endtask

    initial begin
        rst_ni = 1'b0; irq_bi = '0; sgi_req_i = 1'b0; sgi_code_bi = '0;
        cfg_we_i = 1'b0; cfg_addr_bi = '0; cfg_wdata_bi = '0; irq_ack_i = 1'b0;
        tick();
        test_reset();
        test_priority();
        test_enable_gate();
        test_latency();
        test_level();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
